// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: W-stage result source encodings and the
// write-back arbiter's buffered entry and FSM state.
package riscv_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/mux3to1.sv
// Three-input result mux; the unused fourth select code falls back to d0.
module mux3to1
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (s)
            RESULT_MEM: y = d1;
            RESULT_PC4: y = d2;
            default:    y = d0;
        endcase
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the W stage and a
// buffered stream of MDU results, forcing a stall slot when results starve.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [1:0]  ResultSrcW,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] PCPlus4W,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic        stall_o,
    output logic [31:0] pend_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] OCC_FULL  = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(STARVE_LIMIT - 1);

    wb_entry_t        ent [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic [WW-1:0]    wait_cnt;
    wb_state_t        state;

    logic        live;
    logic        full;
    logic        empty;
    logic        in_force;
    logic        push;
    logic        pop;
    logic        blocked;
    logic [31:0] pipe_wd;
    logic [31:0] pend;
    wb_entry_t   head;

    assign live     = RegWriteW && (RdW != 5'd0);
    assign full     = (occ == OCC_FULL);
    assign empty    = (occ == '0);
    assign in_force = (state == FORCE);
    assign head     = ent[rd_ptr];

    assign mdu_ready = !reset && !full;
    // rd=0 offers are handshaken but never stored.
    assign push      = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign pop       = !reset && !empty && (in_force || !live);
    assign blocked   = !reset && !empty && live && !in_force;
    assign stall_o   = !reset && in_force;

    mux3to1 #(.WIDTH(32)) u_result_mux (
        .d0 (ALUResultW),
        .d1 (ReadDataW),
        .d2 (PCPlus4W),
        .s  (ResultSrcW),
        .y  (pipe_wd)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_rd = 5'd0;
        rf_wd = 32'd0;
        if (pop) begin
            rf_we = 1'b1;
            rf_rd = head.rd;
            rf_wd = head.data;
        end else if (!reset && live) begin
            rf_we = 1'b1;
            rf_rd = RdW;
            rf_wd = pipe_wd;
        end
    end

    // Derived only from stored entries, so it tracks the FIFO registers.
    always_comb begin
        pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) pend[ent[i].rd] = 1'b1;
        end
        pend_mask = reset ? 32'd0 : pend;
    end

    always_ff @(posedge clk) begin
        if (push) ent[wr_ptr] <= '{rd: mdu_rd, data: mdu_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_vld  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            wait_cnt <= '0;
            state    <= NORMAL;
        end else begin
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase

            if (pop)          wait_cnt <= '0;
            else if (blocked) wait_cnt <= wait_cnt + WW'(1);

            case (state)
                NORMAL:  if (blocked && wait_cnt == WAIT_LAST) state <= FORCE;
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Cycle-by-cycle scoreboard bench for the write-back port arbiter.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int SLIM  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [1:0]  ResultSrcW = '0;
    logic [31:0] ALUResultW = '0;
    logic [31:0] ReadDataW = '0;
    logic [31:0] PCPlus4W = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_o;
    logic [31:0] pend_mask;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd),
        .stall_o    (stall_o),
        .pend_mask  (pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        stall;
        logic        ready;
        logic [31:0] pend;
        int          id;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc_id = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check_eq($sformatf("c%0d_we", e.id), {31'd0, rf_we}, {31'd0, e.we});
            check_eq($sformatf("c%0d_rd", e.id), {27'd0, rf_rd}, {27'd0, e.rd});
            check_eq($sformatf("c%0d_wd", e.id), rf_wd, e.wd);
            check_eq($sformatf("c%0d_stall", e.id), {31'd0, stall_o}, {31'd0, e.stall});
            check_eq($sformatf("c%0d_ready", e.id), {31'd0, mdu_ready}, {31'd0, e.ready});
            check_eq($sformatf("c%0d_pend", e.id), pend_mask, e.pend);
        end
    end

    function automatic logic [31:0] bit_of(input int n);
        return 32'd1 << n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteW = 1'b0; RdW = '0; ResultSrcW = '0;
        ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu);
        RegWriteW = 1'b1; RdW = rd; ResultSrcW = src; ALUResultW = alu;
        ReadDataW = 32'h2222_0000; PCPlus4W = 32'h3333_0000;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = 1'b1; mdu_rd = rd; mdu_data = d;
    endtask

    task automatic expc(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic stall, input logic ready, input logic [31:0] pend);
        exp_t x;
        x.we = we; x.rd = rd; x.wd = wd; x.stall = stall;
        x.ready = ready; x.pend = pend; x.id = cyc_id;
        cyc_id++;
        expq.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: everything quiet.
        tick(); reset = 1'b1; idle(); expc(0, 0, 0, 0, 0, 0);
        tick(); expc(0, 0, 0, 0, 0, 0);

        // Single MDU result, one cycle of latency.
        tick(); reset = 1'b0; offer(5, 32'hAA); expc(0, 0, 0, 0, 1, 0);
        tick(); idle(); expc(1, 5, 32'hAA, 0, 1, bit_of(5));
        tick(); expc(0, 0, 0, 0, 1, 0);

        // Pipeline writes, each result source.
        tick(); pipe(3, 2'b10, 32'h111); PCPlus4W = 32'h104; expc(1, 3, 32'h104, 0, 1, 0);
        tick(); pipe(4, 2'b01, 32'h111); ReadDataW = 32'h5A5A; expc(1, 4, 32'h5A5A, 0, 1, 0);
        tick(); pipe(6, 2'b00, 32'h1234); expc(1, 6, 32'h1234, 0, 1, 0);
        tick(); pipe(2, 2'b11, 32'h4321); expc(1, 2, 32'h4321, 0, 1, 0);
        tick(); pipe(0, 2'b00, 32'hFFFF); expc(0, 0, 0, 0, 1, 0);

        // Starvation: fill under continuous live writes, then forced slot.
        tick(); pipe(10, 2'b00, 32'h1000); offer(7, 32'h77); expc(1, 10, 32'h1000, 0, 1, 0);
        tick(); pipe(10, 2'b00, 32'h1001); offer(8, 32'h88); expc(1, 10, 32'h1001, 0, 1, bit_of(7));
        tick(); pipe(10, 2'b00, 32'h1002); offer(9, 32'h99);
        expc(1, 10, 32'h1002, 0, 0, bit_of(7) | bit_of(8));
        tick(); pipe(10, 2'b00, 32'h1003); expc(1, 10, 32'h1003, 0, 0, bit_of(7) | bit_of(8));
        tick(); pipe(10, 2'b00, 32'h1004); expc(1, 10, 32'h1004, 0, 0, bit_of(7) | bit_of(8));
        tick(); pipe(10, 2'b00, 32'h1005); expc(1, 7, 32'h77, 1, 0, bit_of(7) | bit_of(8));
        tick(); mdu_valid = 1'b0; expc(1, 10, 32'h1005, 0, 1, bit_of(8));

        // Push and pop together at occupancy 1.
        tick(); idle(); offer(9, 32'h99); expc(1, 8, 32'h88, 0, 1, bit_of(8));
        tick(); idle(); expc(1, 9, 32'h99, 0, 1, bit_of(9));
        tick(); expc(0, 0, 0, 0, 1, 0);

        // DEPTH+2 back-to-back pushes to wrap the pointers.
        for (int k = 0; k < DEPTH + 2; k++) begin
            tick(); idle(); offer(5'(11 + k), 32'((11 + k) * 16));
            if (k == 0) expc(0, 0, 0, 0, 1, 0);
            else expc(1, 5'(10 + k), 32'((10 + k) * 16), 0, 1, bit_of(10 + k));
        end
        tick(); idle(); expc(1, 14, 32'(14 * 16), 0, 1, bit_of(14));

        // Offer to x0 is swallowed.
        tick(); offer(0, 32'hDEAD); expc(0, 0, 0, 0, 1, 0);
        tick(); idle(); expc(0, 0, 0, 0, 1, 0);

        // Reset with two entries buffered.
        tick(); pipe(20, 2'b00, 32'h2000); offer(21, 32'h21); expc(1, 20, 32'h2000, 0, 1, 0);
        tick(); pipe(20, 2'b00, 32'h2001); offer(22, 32'h22); expc(1, 20, 32'h2001, 0, 1, bit_of(21));
        tick(); idle(); reset = 1'b1; expc(0, 0, 0, 0, 0, 0);
        tick(); reset = 1'b0; expc(0, 0, 0, 0, 1, 0);
        tick(); expc(0, 0, 0, 0, 1, 0);
        tick(); expc(0, 0, 0, 0, 1, 0);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
